// File: rtl/interp_dispatcher.sv
// Fragment dispatcher between the rasteriser and the attribute interpolator.
// Accepts one fragment, drives the interpolator issue/release handshake and presents the result fragment.
module interp_dispatcher #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_bary [3],
  input  logic [31:0] in_vertex [3][8],
  input  logic [2:0]  in_attr_count,
  input  logic [15:0] in_tag,
  input  logic        ip_ready,
  output logic        ip_data_valid,
  output logic [31:0] ip_bary [3],
  output logic [31:0] ip_vertex [3][8],
  output logic [2:0]  ip_attr_count,
  input  logic        ip_calc_done,
  input  logic [31:0] ip_result [8],
  output logic        ip_read_done,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data [8],
  output logic [15:0] out_tag,
  output logic [2:0]  out_attr_count,
  output logic [15:0] frag_count,
  output logic        err_timeout
);

  localparam logic [15:0] LP_TIMEOUT = 16'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_CALC,
    S_RELEASE,
    S_OUTPUT
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        w_accept;
  logic        w_issue;
  logic        w_capture;
  logic        w_emit;
  logic        w_waiting;
  logic [15:0] w_wait_inc;

  logic        r_ip_data_valid;
  logic        r_ip_read_done;
  logic        r_err_timeout;
  logic [31:0] r_ip_bary [3];
  logic [31:0] r_ip_vertex [3][8];
  logic [2:0]  r_ip_attr_count;
  logic [31:0] r_out_data [8];
  logic [15:0] r_out_tag;
  logic [2:0]  r_out_attr_count;
  logic [15:0] r_frag_count;
  logic [15:0] r_wait_cnt;

  // NOTE: the next-state default is assigned first so no branch can leave it unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:      if (in_valid) w_next_state = (in_attr_count == 3'd0) ? S_OUTPUT : S_ISSUE;
      S_ISSUE:     if (ip_ready) w_next_state = S_WAIT_CALC;
      S_WAIT_CALC: if (ip_calc_done) w_next_state = S_RELEASE;
      S_RELEASE:   w_next_state = S_OUTPUT;
      S_OUTPUT:    if (out_ready) w_next_state = S_IDLE;
      default:     w_next_state = S_IDLE;
    endcase
  end

  // NOTE: registers use <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  assign in_ready   = (r_state == S_IDLE);
  assign out_valid  = (r_state == S_OUTPUT);
  assign w_accept   = in_ready && in_valid;
  assign w_issue    = (r_state == S_ISSUE) && ip_ready;
  assign w_waiting  = (r_state == S_WAIT_CALC);
  assign w_capture  = w_waiting && ip_calc_done;
  assign w_emit     = out_valid && out_ready;
  assign w_wait_inc = r_wait_cnt + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ip_data_valid <= 1'b0;
      r_ip_read_done  <= 1'b0;
      r_err_timeout   <= 1'b0;
      r_ip_attr_count <= '0;
      r_out_tag       <= '0;
      r_out_attr_count <= '0;
      r_frag_count    <= '0;
      r_wait_cnt      <= '0;
      // NOTE: the data arrays are cleared on rst because every output must read zero straight after reset.
      for (int unsigned v = 0; v < 3; v++) begin
        r_ip_bary[v] <= '0;
        for (int unsigned a = 0; a < 8; a++) r_ip_vertex[v][a] <= '0;
      end
      for (int unsigned i = 0; i < 8; i++) r_out_data[i] <= '0;
    end else begin
      r_ip_data_valid <= w_issue;
      r_ip_read_done  <= w_capture;

      if (w_accept) begin
        r_ip_bary        <= in_bary;
        r_ip_vertex      <= in_vertex;
        r_ip_attr_count  <= in_attr_count;
        r_out_tag        <= in_tag;
        r_out_attr_count <= in_attr_count;
        if (in_attr_count == 3'd0) begin
          for (int unsigned i = 0; i < 8; i++) r_out_data[i] <= '0;
        end
      end

      // The wait counter saturates at the limit so a very long stall cannot wrap it.
      if (w_issue) begin
        r_wait_cnt <= '0;
      end else if (w_waiting && !ip_calc_done) begin
        if (r_wait_cnt != LP_TIMEOUT) r_wait_cnt <= w_wait_inc;
        if (w_wait_inc == LP_TIMEOUT) r_err_timeout <= 1'b1;
      end

      if (w_capture) begin
        for (int unsigned i = 0; i < 8; i++) begin
          r_out_data[i] <= (i < {29'd0, r_ip_attr_count}) ? ip_result[i] : 32'd0;
        end
      end

      if (w_emit) r_frag_count <= r_frag_count + 16'd1;
    end
  end

  assign ip_data_valid  = r_ip_data_valid;
  assign ip_read_done   = r_ip_read_done;
  assign ip_bary        = r_ip_bary;
  assign ip_vertex      = r_ip_vertex;
  assign ip_attr_count  = r_ip_attr_count;
  assign out_data       = r_out_data;
  assign out_tag        = r_out_tag;
  assign out_attr_count = r_out_attr_count;
  assign frag_count     = r_frag_count;
  assign err_timeout    = r_err_timeout;

endmodule
